// File: rtl/numbers_pkg.sv
// numbers_pkg: shared types and helpers for the numbers library
package numbers_pkg;
  typedef enum logic {MODE_CONCAT, MODE_REPL} pack_mode_t;
  typedef enum logic {ST_IDLE, ST_COLLECT} pack_state_t;
  function automatic int cnt_width(input int num);
    return $clog2(num + 1);
  endfunction
endpackage

// File: rtl/numbers_concat_pack_if.sv
// numbers_concat_pack_if: valid/ready streams around the concat packer
interface numbers_concat_pack_if #(
  parameter int IN_W = 4,
  parameter int NUM = 4
);
  import numbers_pkg::*;
  localparam int OUT_W = IN_W * NUM;
  localparam int CNT_W = cnt_width(NUM);
  logic mode;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  modport master (
    output mode, flush, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_count
  );
  modport slave (
    input mode, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/numbers_repl_unit.sv
// numbers_repl_unit: combinational NUM-fold replication of an IN_W-bit value
module numbers_repl_unit #(
  parameter int IN_W = 4,
  parameter int NUM = 4
) (
  input  logic [IN_W-1:0]     x,
  output logic [IN_W*NUM-1:0] y
);
  assign y = {NUM{x}};
endmodule

// File: rtl/numbers_concat_pack.sv
// numbers_concat_pack: packs NUM beats MSB-first, or replicates one beat, with flush of partial groups
module numbers_concat_pack
  import numbers_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int NUM = 4
) (
  input logic clk,
  input logic rst_n,
  numbers_concat_pack_if.slave bus
);
  localparam int OUT_W = IN_W * NUM;
  localparam int CNT_W = cnt_width(NUM);
  pack_state_t state, state_n;
  pack_mode_t mode_q, mode_n;
  logic [OUT_W-IN_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] count, count_n, cnt_a, load_count;
  logic [OUT_W-1:0] repl, pend, load_data;
  logic accept, repl_go, cat_go, emit, load;
  numbers_repl_unit #(.IN_W(IN_W), .NUM(NUM)) u_repl (.x(bus.in_data), .y(repl));
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  // next group state; acc is kept zero while idle so a partial group needs no masking
  always_comb begin
    accept = bus.in_valid && bus.in_ready;
    repl_go = accept && state == ST_IDLE && bus.mode;
    cat_go = accept && !repl_go;
    cnt_a = count + CNT_W'(cat_go);
    pend = cat_go ? {acc, bus.in_data} : OUT_W'(acc);
    emit = bus.in_ready && ((cat_go && cnt_a == CNT_W'(NUM)) || (bus.flush && cnt_a != '0));
    load = repl_go || emit;
    load_data = repl_go ? repl : pend << ((NUM - int'(cnt_a)) * IN_W);
    load_count = repl_go ? CNT_W'(NUM) : cnt_a;
    acc_n = emit ? '0 : cat_go ? (OUT_W-IN_W)'({acc, bus.in_data}) : acc;
    count_n = emit ? '0 : cnt_a;
    state_n = count_n != '0 ? ST_COLLECT : ST_IDLE;
    mode_n = (cat_go && state == ST_IDLE) ? pack_mode_t'(bus.mode) : mode_q;
  end
  // group registers and the output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mode_q <= MODE_CONCAT;
      acc <= '0;
      count <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_count <= '0;
    end else begin
      state <= state_n;
      mode_q <= mode_n;
      acc <= acc_n;
      count <= count_n;
      bus.out_valid <= load || (bus.out_valid && !bus.out_ready);
      if (load) begin
        bus.out_data <= load_data;
        bus.out_count <= load_count;
      end
    end
  end
endmodule

// File: doc/numbers_concat_pack.md
Name: numbers_concat_pack

Overview:
- Parametrised streaming concatenation/replication packer for the numbers library.
- Collects NUM narrow IN_W-bit beats into one OUT_W = IN_W*NUM word. The first beat lands in the MSBs, as with {a, b, ...}.
- Alternatively replicates a single beat NUM times ({NUM{in_data}}).
- Valid/ready on both sides; a flush request emits a partial group zero-padded in the LSBs.

Parameters:
- IN_W, 4, width of one input beat (>=1).
- NUM, 4, beats per output word / replication factor (>=2).
- OUT_W, IN_W*NUM, output width; derived, must not be overridden.
- CNT_W, $clog2(NUM+1), width of out_count; derived.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = concatenate NUM beats, 1 = replicate one beat; sampled on the first beat of a group.
- flush  input  1  emit pending partial group; sampled only when in_ready=1.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  IN_W  input beat.
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  OUT_W  packed word.
- out_count  output  CNT_W  number of real beats in out_data (1..NUM).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_count=0, beat counter=0, accumulator=0, latched mode=0, state=IDLE.
- in_ready = !out_valid || out_ready (combinational). Full throughput when out_ready is held high.
- Accept = in_valid && in_ready. Out handshake = out_valid && out_ready, which clears out_valid unless a new word is loaded in the same cycle.
- States:
  - IDLE: count==0.
  - COLLECT: 0<count<NUM, concat mode only.
  - The out register is independent of state; only the backpressure gates state progression.
- IDLE, accept, mode=1: out_data <= {NUM{in_data}}, out_count <= NUM, out_valid <= 1. Stay in IDLE.
- IDLE, accept, mode=0: latch mode; acc <= in_data; count <= 1; go to COLLECT.
- COLLECT, accept:
  - acc <= {acc, in_data}; count++.
  - When this is beat NUM: out_data <= full word; out_count <= NUM; out_valid <= 1; count <= 0; go to IDLE.
  - Latency: word visible one cycle after the last beat is accepted.
- The mode input is ignored while in COLLECT; the latched mode governs the group.
- Flush, when in_ready=1 and count>0 (after including any beat accepted the same cycle):
  - out_data <= pending beats left-aligned, remaining LSBs zero.
  - out_count <= beats so far; out_valid <= 1; count <= 0; go to IDLE.
- Flush that completes the group on beat NUM in the same cycle: normal full-word output, no extra word.
- Flush with count==0 and no accepted concat beat: no effect.
- Flush with a replicate-mode accept: that word is emitted normally; flush has nothing else to do.
- Flush while in_ready=0: ignored; the source holds it until in_ready=1.
- out_data and out_count hold stable while out_valid && !out_ready.
- Reset mid-group discards the partial accumulator; the next beat starts a new group.
- Widths:
  - No truncation; the accumulator is exactly OUT_W-IN_W bits plus the incoming beat.
  - Count wraps only via the explicit reset to 0, never by overflow.

Decomposition:
- Package numbers_pkg holds:
  - typedef enum {MODE_CONCAT, MODE_REPL} pack_mode_t.
  - typedef enum {ST_IDLE, ST_COLLECT} pack_state_t.
  - localparam function for the derived CNT_W.
- One natural sub-module: numbers_repl_unit, combinational {NUM{x}} for parametrised IN_W/NUM, reused by other numbers blocks.

Test Plan (defaults IN_W=4, NUM=4):
- Concat: mode=0, beats 0xA,0xB,0xC,0xD, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_data=0xABCD, out_count=4; in_ready stays 1.
- Replicate: mode=1, beat 0x5 -> next cycle out_data=0x5555, out_count=4; back-to-back 0x5 then 0x3 gives 0x5555, then 0x3333 on consecutive cycles.
- Flush: mode=0, beats 0x3, 0x9, then flush=1 with no beat -> out_data=0x3900, out_count=2. Beat 0x7 with flush the same cycle -> 0x7000, count 1.
- Backpressure: complete group 0x1,0x2,0x3,0x4 with out_ready=0 -> out_data=0x1234 held, in_ready=0 for 3 cycles. Raise out_ready -> handshake, and in_ready=1 in the same cycle.
- Reset mid-group: beats 0xF,0xE, then rst_n low one cycle -> all outputs 0. Beats 0x1,0x2,0x3,0x4 -> 0x1234, count 4.
- Mode change mid-group: start concat with 0x8, set mode=1 for beats 0x6,0x4,0x2 -> output 0x8642, count 4; no replicate word emitted.
